// File: rtl/mux8_rr_arbiter_pkg.sv
// rtl/mux8_rr_arbiter_pkg.sv - shared types and constants for the 8-way round-robin mux arbiter
package mux8_rr_arbiter_pkg;

  localparam int NUM_SRC = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// rtl/mux8_rr_arbiter_if.sv - request/mux handshake bundle between requesters, arbiter and mux
interface mux8_rr_arbiter_if;
  import mux8_rr_arbiter_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic               pause;
  logic               y_in;
  logic [SEL_W-1:0]   sel;
  logic               en_n;
  logic [NUM_SRC-1:0] grant;
  logic               data_q;
  logic [SEL_W-1:0]   src_q;
  logic               data_valid;

  // Requesting logic / mux side
  modport master (
    output req, pause, y_in,
    input  sel, en_n, grant, data_q, src_q, data_valid
  );

  // Arbiter side
  modport slave (
    input  req, pause, y_in,
    output sel, en_n, grant, data_q, src_q, data_valid
  );

endinterface

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin search: first set req bit after last, wrapping 7->0
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] w_pos;
  logic             w_found;

  // Walk from last+1 upward; 3-bit arithmetic wraps 7->0 for free
  always_comb begin
    any     = |req;
    idx     = '0;
    w_pos   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_pos = last + SEL_W'(1) + SEL_W'(k);
      if (!w_found && req[w_pos]) begin
        idx     = w_pos;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin time-sharing of one 8:1 mux with a disabled gap between grants
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int SLOT_CYCLES = 4,
  parameter int CNT_W       = 8
)
(
  input  logic               clk,
  input  logic               rst,
  mux8_rr_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_GRANT   = GRANT;
  localparam logic [1:0] S_RELEASE = RELEASE;

  localparam logic [CNT_W-1:0]   SLOT_LOAD = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [NUM_SRC-1:0] ONE_HOT0  = {{(NUM_SRC-1){1'b0}}, 1'b1};

  logic [1:0]         r_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_en_n;
  logic [NUM_SRC-1:0] r_grant;
  logic               r_data_q;
  logic [SEL_W-1:0]   r_src_q;
  logic               r_data_valid;
  logic [SEL_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_any;
  logic [SEL_W-1:0]   w_idx;
  logic               w_can_arb;
  logic               w_end_grant;

  rr_pick8 u_pick (
    .req  (bus.req),
    .last (r_last),
    .any  (w_any),
    .idx  (w_idx)
  );

  // A new grant may start from IDLE or RELEASE; a grant ends on request drop or slot expiry
  always_comb begin
    w_can_arb   = !bus.pause && w_any;
    w_end_grant = !bus.req[r_sel] || (r_cnt == '0);
  end

  // Arbiter FSM; every output is a flop so the mux sees glitch-free select/enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_en_n       <= 1'b1;
      r_grant      <= '0;
      r_data_q     <= 1'b0;
      r_src_q      <= '0;
      r_data_valid <= 1'b0;
      r_last       <= SEL_W'(NUM_SRC - 1);
      r_cnt        <= '0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_RELEASE: begin
          if (w_can_arb) begin
            r_state <= S_GRANT;
            r_sel   <= w_idx;
            r_en_n  <= 1'b0;
            r_grant <= ONE_HOT0 << w_idx;
            r_cnt   <= SLOT_LOAD;
          end else begin
            r_state <= S_IDLE;
            r_en_n  <= 1'b1;
            r_grant <= '0;
          end
        end
        S_GRANT: begin
          if (w_end_grant) begin
            // y_in is still driven by the mux on this edge since en_n was 0 up to now
            r_state      <= S_RELEASE;
            r_en_n       <= 1'b1;
            r_grant      <= '0;
            r_last       <= r_sel;
            r_data_q     <= bus.y_in;
            r_src_q      <= r_sel;
            r_data_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_en_n  <= 1'b1;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Drive the bundle from the registered state
  always_comb begin
    bus.sel        = r_sel;
    bus.en_n       = r_en_n;
    bus.grant      = r_grant;
    bus.data_q     = r_data_q;
    bus.src_q      = r_src_q;
    bus.data_valid = r_data_valid;
  end

endmodule
